bp_me_cache_pkt_arbiter: RTL



---
 rtl/bp_me_cache_pkt_arbiter_if.sv | 54 +++++
 rtl/bp_me_cache_pkt_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/bp_me_cache_pkt_arbiter_if.sv
// ============================================================================
// Module   : bp_me_cache_pkt_arbiter_if
// Brief    : Requester/cache bus bundle for bp_me_cache_pkt_arbiter.
//            Optional lock input present when BP_ME_CACHE_ARB_LOCK_EN is set.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface bp_me_cache_pkt_arbiter_if #(
    parameter int num_req_p     = 2,
    parameter int pkt_width_p   = 64 + 40 + 8 + 5,
    parameter int data_width_p  = 64,
    parameter int outstanding_p = 8
);
    localparam int CNT_W = $clog2(outstanding_p + 1);

    logic [num_req_p*pkt_width_p-1:0] req_pkt_i;
    logic [num_req_p-1:0]             req_v_i;
    logic [num_req_p-1:0]             req_ready_o;
`ifdef BP_ME_CACHE_ARB_LOCK_EN
    logic [num_req_p-1:0]             req_lock_i;
`endif
    logic [pkt_width_p-1:0]           cache_pkt_o;
    logic                             v_o;
    logic                             ready_i;
    logic [data_width_p-1:0]          data_i;
    logic                             v_i;
    logic                             yumi_o;
    logic [data_width_p-1:0]          resp_data_o;
    logic [num_req_p-1:0]             resp_v_o;
    logic [num_req_p-1:0]             resp_yumi_i;
    logic [CNT_W-1:0]                 outstanding_o;
    logic                             error_o;

    modport slave (
`ifdef BP_ME_CACHE_ARB_LOCK_EN
        input  req_lock_i,
`endif
        input  req_pkt_i, req_v_i, ready_i, data_i, v_i, resp_yumi_i,
        output req_ready_o, cache_pkt_o, v_o, yumi_o, resp_data_o, resp_v_o,
        output outstanding_o, error_o
    );

    modport master (
`ifdef BP_ME_CACHE_ARB_LOCK_EN
        output req_lock_i,
`endif
        output req_pkt_i, req_v_i, ready_i, data_i, v_i, resp_yumi_i,
        input  req_ready_o, cache_pkt_o, v_o, yumi_o, resp_data_o, resp_v_o,
        input  outstanding_o, error_o
    );
endinterface

`default_nettype wire

// File: rtl/bp_me_cache_pkt_arbiter.sv
// ============================================================================
// Module   : bp_me_cache_pkt_arbiter
// Brief    : Round-robin share of one bsg_cache packet port; an order FIFO of
//            requester IDs steers in-order responses back. Optional macro
//            BP_ME_CACHE_ARB_LOCK_EN adds per-requester grant locking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bp_me_cache_pkt_arbiter #(
    parameter int num_req_p     = 2,
    parameter int pkt_width_p   = 64 + 40 + 8 + 5,
    parameter int data_width_p  = 64,
    parameter int outstanding_p = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    bp_me_cache_pkt_arbiter_if.slave bus
);
    localparam int LG_REQ = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int LG_OUT = (outstanding_p > 1) ? $clog2(outstanding_p) : 1;
    localparam int CNT_W  = $clog2(outstanding_p + 1);

    localparam logic [LG_OUT-1:0] C_LAST_SLOT = LG_OUT'(outstanding_p - 1);
    localparam logic [CNT_W-1:0]  C_FULL_CNT  = CNT_W'(outstanding_p);

    // Requester index base+off with explicit wrap for non-power-of-2 counts.
    function automatic logic [LG_REQ-1:0] rr_idx(input logic [LG_REQ-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= num_req_p) s = s - num_req_p;
        return LG_REQ'(s);
    endfunction

    logic [LG_REQ-1:0] ptr_q, ptr_d;
    logic [LG_OUT-1:0] wptr_q, wptr_d;
    logic [LG_OUT-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              error_q, error_d;
    logic [LG_REQ-1:0] fifo_mem_q [outstanding_p];

    logic [LG_REQ-1:0]    w_rr_grant;
    logic                 w_rr_found;
    logic [LG_REQ-1:0]    w_sel_id;
    logic                 w_sel_v;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_v;
    logic                 w_accept;
    logic [LG_REQ-1:0]    w_head;
    logic                 w_resp_ok;
    logic                 w_pop;
    logic [num_req_p-1:0] w_req_ready;
    logic [num_req_p-1:0] w_resp_v;

    always_comb begin
        w_rr_grant = ptr_q;
        w_rr_found = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            if (!w_rr_found && bus.req_v_i[rr_idx(ptr_q, i)]) begin
                w_rr_found = 1'b1;
                w_rr_grant = rr_idx(ptr_q, i);
            end
        end
    end

`ifdef BP_ME_CACHE_ARB_LOCK_EN
    // Owner is the most recently accepted requester; its lock bit pins the grant.
    logic [LG_REQ-1:0] owner_q, owner_d;
    logic              owner_v_q, owner_v_d;
    logic              w_locked;

    always_comb begin
        w_locked  = owner_v_q & bus.req_lock_i[owner_q];
        w_sel_id  = w_locked ? owner_q : w_rr_grant;
        w_sel_v   = w_locked ? bus.req_v_i[owner_q] : w_rr_found;
        owner_d   = w_accept ? w_sel_id : owner_q;
        owner_v_d = owner_v_q | w_accept;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            owner_q   <= '0;
            owner_v_q <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            owner_v_q <= owner_v_d;
        end
    end
`else
    always_comb begin
        w_sel_id = w_rr_grant;
        w_sel_v  = w_rr_found;
    end
`endif

    // Full blocks new grants even if a pop lands this cycle: no resp->v_o path.
    always_comb begin
        w_full    = (count_q == C_FULL_CNT);
        w_empty   = (count_q == '0);
        w_v       = ~reset_i & w_sel_v & ~w_full;
        w_accept  = w_v & bus.ready_i;
        w_head    = fifo_mem_q[rptr_q];
        w_resp_ok = ~reset_i & bus.v_i & ~w_empty;
        w_pop     = w_resp_ok & bus.resp_yumi_i[w_head];

        w_req_ready           = '0;
        w_req_ready[w_sel_id] = w_accept;
        w_resp_v              = '0;
        w_resp_v[w_head]      = w_resp_ok;
    end

    assign bus.v_o           = w_v;
    assign bus.req_ready_o   = w_req_ready;
    assign bus.cache_pkt_o   = bus.req_pkt_i[w_sel_id*pkt_width_p +: pkt_width_p];
    assign bus.yumi_o        = w_pop;
    assign bus.resp_v_o      = w_resp_v;
    assign bus.resp_data_o   = bus.data_i;
    assign bus.outstanding_o = count_q;
    assign bus.error_o       = error_q;

    always_comb begin
        ptr_d   = w_accept ? rr_idx(w_sel_id, 1) : ptr_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (w_accept) wptr_d = (wptr_q == C_LAST_SLOT) ? '0 : wptr_q + 1'b1;
        if (w_pop)    rptr_d = (rptr_q == C_LAST_SLOT) ? '0 : rptr_q + 1'b1;
        count_d = count_q + CNT_W'(w_accept) - CNT_W'(w_pop);
        error_d = error_q | (bus.v_i & w_empty);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && w_accept) fifo_mem_q[wptr_q] <= w_sel_id;
    end

endmodule

`default_nettype wire
